// File: rtl/output_buffer_unit.sv
// Output unit: register file feeding a show-ahead FIFO drained over valid/ready.
// Define OUT_STICKY_ERR_EN to make overflow sticky until reset (default: 1-cycle pulse).
module output_buffer_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int ZERO_REG   = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              mem_write,
    input  logic                              out_req,
    input  logic [ADDR_W-1:0]                 address,
    input  logic [DATA_W-1:0]                 writedata,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [DATA_W-1:0]                 dataout,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              overflow
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] fifo [FIFO_DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [CW-1:0]     count;

    logic              zero_sel;
    logic [DATA_W-1:0] rd_val;
    logic              wr_en;
    logic              push;
    logic              pop;
    logic              full;
    logic              accept;
    logic              drop;

    assign zero_sel = (ZERO_REG != 0) && (address == '0);
    assign rd_val   = zero_sel ? '0 : regs[address];
    assign wr_en    = mem_write && !zero_sel;

    // A write takes the cycle; a coincident out request is ignored outright.
    assign push   = out_req && !mem_write;
    assign pop    = out_valid && out_ready;
    assign full   = (count == CW'(FIFO_DEPTH));
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? fifo[rp] : '0;
    assign fifo_count = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            dataout  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[address] <= writedata;
            end
            if (accept) begin
                fifo[wp] <= rd_val;
                wp       <= wp + PW'(1);
            end
            if (pop) begin
                rp      <= rp + PW'(1);
                dataout <= fifo[rp];
            end
            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !accept) begin
                count <= count - CW'(1);
            end
`ifdef OUT_STICKY_ERR_EN
            overflow <= overflow | drop;
`else
            overflow <= drop;
`endif
        end
    end

endmodule

// File: tb/tb_output_buffer_unit.sv
// Directed testbench for output_buffer_unit.
module tb_output_buffer_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_write;
    logic        out_req;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] dataout;
    logic [2:0]  fifo_count;
    logic        overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    output_buffer_unit dut (
        .clock      (clock),
        .reset      (reset),
        .mem_write  (mem_write),
        .out_req    (out_req),
        .address    (address),
        .writedata  (writedata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .dataout    (dataout),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        mem_write = 1'b0;
        out_req   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        mem_write = 1'b1; out_req = 1'b0; address = a; writedata = d;
        tick();
        idle();
    endtask

    task automatic req(input logic [4:0] a);
        mem_write = 1'b0; out_req = 1'b1; address = a;
        tick();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(); out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h0) $display("FAIL rst_data got %h exp 0", out_data); else pass_cnt++;
        total_cnt++; if (dataout !== 32'h0) $display("FAIL rst_dataout got %h exp 0", dataout); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL rst_count got %0d exp 0", fifo_count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", overflow); else pass_cnt++;
    endtask

    task automatic test_basic();
        wr(5'd3, 32'hDEADBEEF);
        out_ready = 1'b1;
        req(5'd3);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL t1_valid got %b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'hDEADBEEF) $display("FAIL t1_data got %h exp deadbeef", out_data); else pass_cnt++;
        tick();
        total_cnt++; if (dataout !== 32'hDEADBEEF) $display("FAIL t1_dataout got %h exp deadbeef", dataout); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL t1_count got %0d exp 0", fifo_count); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL t1_valid_off got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        wr(5'd0, 32'h1234);
        out_ready = 1'b1;
        req(5'd0);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL t2_valid got %b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h0) $display("FAIL t2_data got %h exp 0", out_data); else pass_cnt++;
        tick();
        total_cnt++; if (dataout !== 32'h0) $display("FAIL t2_dataout got %h exp 0", dataout); else pass_cnt++;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) wr(5'(i), 32'(i));
        for (int i = 1; i <= 4; i++) req(5'(i));
        total_cnt++; if (fifo_count !== 3'd4) $display("FAIL t3_full got %0d exp 4", fifo_count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL t3_ovf_pre got %b exp 0", overflow); else pass_cnt++;
        req(5'd5);
        total_cnt++; if (overflow !== 1'b1) $display("FAIL t3_ovf got %b exp 1", overflow); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd4) $display("FAIL t3_count got %0d exp 4", fifo_count); else pass_cnt++;
        tick();
`ifdef OUT_STICKY_ERR_EN
        total_cnt++; if (overflow !== 1'b1) $display("FAIL t3_ovf_hold got %b exp 1", overflow); else pass_cnt++;
`else
        total_cnt++; if (overflow !== 1'b0) $display("FAIL t3_ovf_pulse got %b exp 0", overflow); else pass_cnt++;
`endif
        total_cnt++; if (out_data !== 32'd1) $display("FAIL t3_head got %h exp 1", out_data); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++; if (dataout !== 32'(i)) $display("FAIL t3_drain%0d got %h exp %h", i, dataout, 32'(i)); else pass_cnt++;
        end
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL t3_empty got %0d exp 0", fifo_count); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_priority();
        out_ready = 1'b0;
        wr(5'd2, 32'h22);
        req(5'd2);
        mem_write = 1'b1; out_req = 1'b1; address = 5'd7; writedata = 32'hA5;
        tick();
        idle();
        total_cnt++; if (fifo_count !== 3'd1) $display("FAIL t4_count got %0d exp 1", fifo_count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL t4_ovf got %b exp 0", overflow); else pass_cnt++;
        req(5'd7);
        total_cnt++; if (fifo_count !== 3'd2) $display("FAIL t4_count2 got %0d exp 2", fifo_count); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (dataout !== 32'h22) $display("FAIL t4_first got %h exp 22", dataout); else pass_cnt++;
        total_cnt++; if (out_data !== 32'hA5) $display("FAIL t4_reg7 got %h exp a5", out_data); else pass_cnt++;
        tick();
        total_cnt++; if (dataout !== 32'hA5) $display("FAIL t4_second got %h exp a5", dataout); else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) req(5'd7);
        total_cnt++; if (fifo_count !== 3'd3) $display("FAIL t5_queued got %0d exp 3", fifo_count); else pass_cnt++;
        out_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL t5_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL t5_count got %0d exp 0", fifo_count); else pass_cnt++;
        total_cnt++; if (dataout !== 32'h0) $display("FAIL t5_dataout got %h exp 0", dataout); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h0) $display("FAIL t5_data got %h exp 0", out_data); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_seq [5];
        exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33;
        exp_seq[3] = 32'h44; exp_seq[4] = 32'h55;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(5'(i + 1), exp_seq[i]);
        for (int i = 1; i <= 4; i++) req(5'(i));
        total_cnt++; if (fifo_count !== 3'd4) $display("FAIL t6_full got %0d exp 4", fifo_count); else pass_cnt++;
        out_ready = 1'b1;
        req(5'd5);
        total_cnt++; if (fifo_count !== 3'd4) $display("FAIL t6_count got %0d exp 4", fifo_count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL t6_ovf got %b exp 0", overflow); else pass_cnt++;
        total_cnt++; if (dataout !== 32'h11) $display("FAIL t6_pop got %h exp 11", dataout); else pass_cnt++;
        for (int i = 1; i < 5; i++) begin
            tick();
            total_cnt++; if (dataout !== exp_seq[i]) $display("FAIL t6_drain%0d got %h exp %h", i, dataout, exp_seq[i]); else pass_cnt++;
        end
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL t6_empty got %0d exp 0", fifo_count); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; mem_write = 1'b0; out_req = 1'b0;
        address = '0; writedata = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_reg();
        test_overflow();
        test_priority();
        test_reset_mid_drain();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
